// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand resolution and load-use hazard hold.
// Optional x0 forwarding guard is enabled by defining FWD_X0_GUARD_EN.
module ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_write_reg,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  ex_stall,
  input  logic [1:0]            src1Forward_pi,
  input  logic [1:0]            src2Forward_pi,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic                  mem_is_load,
  input  logic [XLEN-1:0]       wb_write_data,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic                  ex_valid,
  output logic                  ex_go,
  output logic [XLEN-1:0]       ex_op1,
  output logic [XLEN-1:0]       ex_op2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_write_reg,
  output logic                  ex_mem_read,
  output logic                  load_use_stall
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_op1;
  logic [XLEN-1:0]       r_op2;
  logic                  r_write_reg;
  logic                  r_mem_read;

  logic [1:0]            w_code1;
  logic [1:0]            w_code2;
  logic                  w_lus;
  logic                  w_go;
  logic                  w_ready;
  logic [XLEN-1:0]       w_op1;
  logic [XLEN-1:0]       w_op2;

  function automatic logic [XLEN-1:0] resolve(input logic [1:0]      code,
                                              input logic [XLEN-1:0] mem_d,
                                              input logic [XLEN-1:0] wb_d,
                                              input logic [XLEN-1:0] held);
    case (code)
      2'd2:    resolve = mem_d;
      2'd1:    resolve = wb_d;
      default: resolve = held;
    endcase
  endfunction

`ifdef FWD_X0_GUARD_EN
  // x0 never takes forwarded data and always reads as zero.
  assign w_code1 = (r_rs1 == '0) ? 2'd0 : src1Forward_pi;
  assign w_code2 = (r_rs2 == '0) ? 2'd0 : src2Forward_pi;
  assign w_op1   = (r_rs1 == '0) ? '0 : resolve(w_code1, mem_alu_result, wb_write_data, r_op1);
  assign w_op2   = (r_rs2 == '0) ? '0 : resolve(w_code2, mem_alu_result, wb_write_data, r_op2);
`else
  assign w_code1 = src1Forward_pi;
  assign w_code2 = src2Forward_pi;
  assign w_op1   = resolve(w_code1, mem_alu_result, wb_write_data, r_op1);
  assign w_op2   = resolve(w_code2, mem_alu_result, wb_write_data, r_op2);
`endif

  assign w_lus   = r_valid && mem_is_load && ((w_code1 == 2'd2) || (w_code2 == 2'd2));
  assign w_go    = r_valid && !w_lus && !ex_stall;
  assign w_ready = !r_valid || w_go;

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_write_reg <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (id_valid && w_ready) begin
      r_valid     <= 1'b1;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_op1       <= id_rs1_data;
      r_op2       <= id_rs2_data;
      r_write_reg <= id_write_reg;
      r_mem_read  <= id_mem_read;
    end else if (w_go) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Capture forwarded data while held, except MEM data that is still an in-flight load.
      if (!(w_lus && (w_code1 == 2'd2))) r_op1 <= w_op1;
      if (!(w_lus && (w_code2 == 2'd2))) r_op2 <= w_op2;
    end
  end

  assign id_ready       = w_ready;
  assign ex_valid       = r_valid;
  assign ex_go          = w_go;
  assign load_use_stall = w_lus;
  assign ex_rs1         = r_rs1;
  assign ex_rs2         = r_rs2;
  assign ex_rd          = r_rd;
  assign ex_write_reg   = r_write_reg;
  assign ex_mem_read    = r_mem_read;
  assign ex_op1         = w_op1;
  assign ex_op2         = w_op2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: forwarding-vector table plus hold, load-use, flush and reset sequences.
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid, id_ready;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data;
  logic            id_write_reg, id_mem_read;
  logic            flush, ex_stall;
  logic [1:0]      src1Forward_pi, src2Forward_pi;
  logic [XLEN-1:0] mem_alu_result, wb_write_data;
  logic            mem_is_load;
  logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic            ex_valid, ex_go, ex_write_reg, ex_mem_read, load_use_stall;
  logic [XLEN-1:0] ex_op1, ex_op2;

  ex_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rd(id_rd), .id_write_reg(id_write_reg), .id_mem_read(id_mem_read),
    .flush(flush), .ex_stall(ex_stall),
    .src1Forward_pi(src1Forward_pi), .src2Forward_pi(src2Forward_pi),
    .mem_alu_result(mem_alu_result), .mem_is_load(mem_is_load), .wb_write_data(wb_write_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_valid(ex_valid), .ex_go(ex_go),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_write_reg(ex_write_reg),
    .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RW-1:0]   rd;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [RW-1:0]   rs1, rs2;
    logic [XLEN-1:0] d1, d2;
    logic [1:0]      c1, c2;
    logic [XLEN-1:0] mem, wb;
    logic [XLEN-1:0] e1, e2;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every cycle EX/MEM captures, the operands must match the oldest expectation.
  always @(negedge clk) begin
    if (ex_go === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_go", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_op1", ex_op1, e.op1);
        chk("sb_op2", ex_op2, e.op2);
        chk("sb_rd", {27'd0, ex_rd}, {27'd0, e.rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; flush = 0; ex_stall = 0; mem_is_load = 0;
    src1Forward_pi = 0; src2Forward_pi = 0;
  endtask

  task automatic issue(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [RW-1:0] rd);
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2; id_rd = rd;
    id_valid = 1;
    step();
    id_valid = 0;
  endtask

  vec_t vt[6];

  initial begin
    logic [XLEN-1:0] x0_exp1, x0_exp2;
`ifdef FWD_X0_GUARD_EN
    x0_exp1 = 32'h0;  x0_exp2 = 32'h0;
`else
    x0_exp1 = 32'h77; x0_exp2 = 32'h99;
`endif
    vt[0] = '{5, 3, 32'h11, 32'h22, 2, 0, 32'hAA,   32'h55,   32'hAA,   32'h22};
    vt[1] = '{7, 8, 32'h31, 32'h32, 1, 2, 32'h1234, 32'h5678, 32'h5678, 32'h1234};
    vt[2] = '{9, 4, 32'h41, 32'h42, 3, 3, 32'hF0,   32'hF1,   32'h41,   32'h42};
    vt[3] = '{2, 6, 32'h51, 32'h52, 0, 1, 32'hE0,   32'hE1,   32'h51,   32'hE1};
    vt[4] = '{0, 4, 32'h61, 32'h62, 2, 0, 32'h77,   32'h88,   x0_exp1,  32'h62};
    vt[5] = '{1, 0, 32'h71, 32'h72, 0, 1, 32'h66,   32'h99,   32'h71,   x0_exp2};

    reset = 1; idle();
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_write_reg = 0; id_mem_read = 0; mem_alu_result = 0; wb_write_data = 0;
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_ready", id_ready, 1);
    chk("rst_go", ex_go, 0);
    chk("rst_lus", load_use_stall, 0);
    chk("rst_op1", ex_op1, 0);
    reset = 0;
    step();

    // Table: one instruction per slot, forwarding applied in its EX cycle.
    for (int i = 0; i < 6; i++) begin
      issue(vt[i].rs1, vt[i].rs2, vt[i].d1, vt[i].d2, RW'(i + 1));
      src1Forward_pi = vt[i].c1; src2Forward_pi = vt[i].c2;
      mem_alu_result = vt[i].mem; wb_write_data = vt[i].wb;
      #1;
      chk($sformatf("v%0d_op1", i), ex_op1, vt[i].e1);
      chk($sformatf("v%0d_op2", i), ex_op2, vt[i].e2);
      chk($sformatf("v%0d_go", i), ex_go, 1);
      sbq.push_back('{vt[i].e1, vt[i].e2, RW'(i + 1)});
      step();
      chk($sformatf("v%0d_bubble", i), ex_valid, 0);
      idle();
    end

    // WB-forwarded data survives a two-cycle downstream stall after the producer retires.
    issue(5, 3, 32'h11, 32'h22, 7);
    src1Forward_pi = 1; wb_write_data = 32'h55; ex_stall = 1;
    #1;
    chk("hold_op1_a", ex_op1, 32'h55);
    chk("hold_go_a", ex_go, 0);
    chk("hold_ready_a", id_ready, 0);
    step();
    src1Forward_pi = 0; wb_write_data = 32'h99;
    #1;
    chk("hold_op1_b", ex_op1, 32'h55);
    step();
    ex_stall = 0;
    #1;
    chk("hold_op1_c", ex_op1, 32'h55);
    chk("hold_go_c", ex_go, 1);
    chk("hold_rs1", ex_rs1, 5);
    sbq.push_back('{32'h55, 32'h22, 5'd7});
    step();
    idle();

    // Load-use: MEM data of an in-flight load must not be latched.
    issue(1, 6, 32'h41, 32'h22, 10);
    src2Forward_pi = 2; mem_is_load = 1; mem_alu_result = 32'hDEAD;
    #1;
    chk("lu_stall", load_use_stall, 1);
    chk("lu_go", ex_go, 0);
    chk("lu_ready", id_ready, 0);
    step();
    src2Forward_pi = 0; mem_is_load = 0; ex_stall = 1;
    #1;
    chk("lu_nolatch_op2", ex_op2, 32'h22);
    chk("lu_stall_off", load_use_stall, 0);
    step();
    ex_stall = 0; src2Forward_pi = 1; wb_write_data = 32'hBEEF;
    #1;
    chk("lu_op2", ex_op2, 32'hBEEF);
    chk("lu_go2", ex_go, 1);
    chk("lu_op1", ex_op1, 32'h41);
    sbq.push_back('{32'h41, 32'hBEEF, 5'd10});
    step();
    idle();

    // Flush while holding drops both the held and the incoming instruction.
    issue(2, 2, 32'h1, 32'h2, 9);
    ex_stall = 1;
    step();
    flush = 1; id_valid = 1; id_rd = 12; id_rs1_data = 32'h3;
    #1;
    chk("fl_ready", id_ready, 0);
    step();
    idle();
    #1;
    chk("fl_valid", ex_valid, 0);
    chk("fl_rd", ex_rd, 9);
    chk("fl_go", ex_go, 0);
    flush = 1; id_valid = 1; id_rd = 13;
    step();
    idle();
    #1;
    chk("fl_empty_valid", ex_valid, 0);
    step();

    // Back-to-back issue: the next instruction loads on the cycle the current one advances.
    issue(3, 4, 32'h61, 32'h62, 20);
    id_rs1_data = 32'h71; id_rs2_data = 32'h72; id_rd = 21; id_valid = 1;
    #1;
    chk("b2b_ready", id_ready, 1);
    chk("b2b_go", ex_go, 1);
    sbq.push_back('{32'h61, 32'h62, 5'd20});
    step();
    id_valid = 0;
    #1;
    chk("b2b_rd", ex_rd, 21);
    sbq.push_back('{32'h71, 32'h72, 5'd21});
    step();
    chk("b2b_drain", ex_valid, 0);

    // Asynchronous reset in the middle of a hold.
    id_write_reg = 1; id_mem_read = 1;
    issue(5, 6, 32'h31, 32'h32, 3);
    ex_stall = 1;
    #1;
    chk("ar_wr_before", ex_write_reg, 1);
    step();
    reset = 1;
    #1;
    chk("ar_valid", ex_valid, 0);
    chk("ar_rd", ex_rd, 0);
    chk("ar_rs1", ex_rs1, 0);
    chk("ar_rs2", ex_rs2, 0);
    chk("ar_op1", ex_op1, 0);
    chk("ar_op2", ex_op2, 0);
    chk("ar_wr", ex_write_reg, 0);
    chk("ar_mr", ex_mem_read, 0);
    chk("ar_go", ex_go, 0);
    #10;
    reset = 0;
    idle();
    #1;
    chk("ar_ready", id_ready, 1);
    chk("ar_valid_after", ex_valid, 0);
    step();
    step();

    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
